axi_lite_gpio_irq: RTL and testbench

Parametrised AXI4-Lite GPIO slave, successor to the fixed Basys 3 GPIO block.
- Generalised button/LED/switch widths and per-button press counters.
- Adds registered AXI handshakes, write-strobe handling, saturating counters and a maskable, level-sensitive press interrupt with write-1-to-clear pending bits.
- Sits between the MicroBlaze AXI interconnect and board I/O.

---
 rtl/gpio_irq_pkg.sv | 33 +++
 rtl/gpio_debounce.sv | 44 ++++
 rtl/axi_lite_gpio_irq.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_gpio_irq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared register offsets, response codes and byte-strobe helpers for the AXI4-Lite GPIO block.
package gpio_irq_pkg;

  localparam logic [31:0] OFF_CONFIG     = 32'h00;
  localparam logic [31:0] OFF_LED        = 32'h04;
  localparam logic [31:0] OFF_SW         = 32'h08;
  localparam logic [31:0] OFF_BTN_LEVEL  = 32'h0C;
  localparam logic [31:0] OFF_IRQ_EN     = 32'h10;
  localparam logic [31:0] OFF_IRQ_PEND   = 32'h14;
  localparam logic [31:0] OFF_COUNT_BASE = 32'h20;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CFG_KEEP_BIT = 0;
  localparam int unsigned CFG_GIE_BIT  = 1;

  typedef enum logic [2:0] {
    RegConfig, RegLed, RegSw, RegBtn, RegIrqEn, RegIrqPend, RegCount, RegNone
  } reg_sel_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    return (old & ~strb_mask(strb)) | (data & strb_mask(strb));
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-channel button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
module gpio_debounce #(
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            press_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], in};
      press_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        // DEB_CYCLES consecutive samples disagreed with the accepted level
        cnt_q   <= '0;
        level_q <= sync_q[1];
        press_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/axi_lite_gpio_irq.sv
// AXI4-Lite GPIO slave with debounced buttons, press counters and a maskable press interrupt.
module axi_lite_gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int unsigned N_BTN              = 4,
  parameter int unsigned N_LED              = 16,
  parameter int unsigned N_SW               = 16,
  parameter int unsigned CNT_W              = 16,
  parameter int unsigned DEB_CYCLES         = 100000,
  parameter bit          CNT_SATURATE       = 1'b1,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic [N_SW-1:0]                 sw,
  input  logic [N_BTN-1:0]                btn,
  output logic [N_LED-1:0]                led,
  output logic                            irq
);

  logic             wr_rdy_q, bvalid_q, ar_rdy_q, rvalid_q, irq_q;
  logic [1:0]       bresp_q, rresp_q, rresp_d;
  logic [31:0]      rdata_q, rd;
  logic [1:0]       cfg_q, cfg_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_SW-1:0]  sw_s0_q, sw_s1_q;
  logic [N_BTN-1:0] irq_en_q, irq_en_d, pend_q, pend_d, pend_clr;
  logic [N_BTN-1:0] btn_level, press;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];
  logic             aw_hs, ar_hs, w_ok, cnt_clr;
  reg_sel_e         wsel, rsel;
  logic [2:0]       rk;
  logic             unused_prot;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  function automatic reg_sel_e decode(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
    logic [31:0] a;
    a = 32'(addr) & ~32'h3;
    if (a == OFF_CONFIG)    return RegConfig;
    if (a == OFF_LED)       return RegLed;
    if (a == OFF_SW)        return RegSw;
    if (a == OFF_BTN_LEVEL) return RegBtn;
    if (a == OFF_IRQ_EN)    return RegIrqEn;
    if (a == OFF_IRQ_PEND)  return RegIrqPend;
    if (a >= OFF_COUNT_BASE && a < OFF_COUNT_BASE + 4 * N_BTN) return RegCount;
    return RegNone;
  endfunction

  function automatic logic [2:0] count_idx(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
    logic [31:0] off;
    off = 32'(addr) - OFF_COUNT_BASE;
    return off[4:2];
  endfunction

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    gpio_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (s_axi_aclk),
      .rstn (s_axi_aresetn),
      .in   (btn[g]),
      .level(btn_level[g]),
      .press(press[g])
    );
  end

  assign aw_hs   = wr_rdy_q & s_axi_awvalid & s_axi_wvalid;
  assign ar_hs   = ar_rdy_q & s_axi_arvalid;
  assign wsel    = decode(s_axi_awaddr);
  assign rsel    = decode(s_axi_araddr);
  assign rk      = count_idx(s_axi_araddr);
  assign w_ok    = wsel inside {RegConfig, RegLed, RegIrqEn, RegIrqPend};
  assign cnt_clr = ar_hs && rsel == RegCount && !cfg_q[CFG_KEEP_BIT];

  always_comb begin
    cfg_d    = cfg_q;
    led_d    = led_q;
    irq_en_d = irq_en_q;
    pend_clr = '0;
    if (aw_hs) begin
      unique case (wsel)
        RegConfig:  cfg_d    = 2'(apply_strb(32'(cfg_q), s_axi_wdata, s_axi_wstrb));
        RegLed:     led_d    = N_LED'(apply_strb(32'(led_q), s_axi_wdata, s_axi_wstrb));
        RegIrqEn:   irq_en_d = N_BTN'(apply_strb(32'(irq_en_q), s_axi_wdata, s_axi_wstrb));
        RegIrqPend: pend_clr = N_BTN'(s_axi_wdata & strb_mask(s_axi_wstrb));
        default: ;
      endcase
    end
    // A new press outranks a same-cycle W1C
    pend_d = (pend_q & ~pend_clr) | (press & irq_en_q);
  end

  always_comb begin
    for (int k = 0; k < N_BTN; k++) begin
      cnt_d[k] = (cnt_clr && rk == 3'(k)) ? '0 : cnt_q[k];
      if (press[k] && !(CNT_SATURATE && &cnt_d[k])) cnt_d[k] = cnt_d[k] + 1'b1;
    end
  end

  always_comb begin
    rd      = '0;
    rresp_d = RESP_OKAY;
    unique case (rsel)
      RegConfig:  rd = 32'(cfg_q);
      RegLed:     rd = 32'(led_q);
      RegSw:      rd = 32'(sw_s1_q);
      RegBtn:     rd = 32'(btn_level);
      RegIrqEn:   rd = 32'(irq_en_q);
      RegIrqPend: rd = 32'(pend_q);
      RegCount: begin
        for (int k = 0; k < N_BTN; k++) if (rk == 3'(k)) rd = 32'(cnt_q[k]);
      end
      default:    rresp_d = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      wr_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      cfg_q    <= '0;
      led_q    <= '0;
      irq_en_q <= '0;
      pend_q   <= '0;
      cnt_q    <= '{default: '0};
      sw_s0_q  <= '0;
      sw_s1_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_rdy_q <= s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~wr_rdy_q;
      if (aw_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      ar_rdy_q <= s_axi_arvalid & ~rvalid_q & ~ar_rdy_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd;
        rresp_q  <= rresp_d;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      cfg_q    <= cfg_d;
      led_q    <= led_d;
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      sw_s0_q  <= sw;
      sw_s1_q  <= sw_s0_q;
      irq_q    <= cfg_q[CFG_GIE_BIT] & |(pend_q & irq_en_q);
    end
  end

  assign s_axi_awready = wr_rdy_q;
  assign s_axi_wready  = wr_rdy_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = ar_rdy_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = C_S_AXI_DATA_WIDTH'(rdata_q);
  assign led           = led_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_axi_lite_gpio_irq.sv
// Scoreboard bench: two instances (saturating and wrapping counters) share all stimulus.
module tb_axi_lite_gpio_irq;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [5:0]  awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [15:0] sw;
  logic [3:0]  btn;

  logic        awready0, wready0, bvalid0, arready0, rvalid0, irq0;
  logic        awready1, wready1, bvalid1, arready1, rvalid1, irq1;
  logic [1:0]  bresp0, rresp0, bresp1, rresp1;
  logic [31:0] rdata0, rdata1;
  logic [15:0] led0, led1;

  always #5 clk = ~clk;

  axi_lite_gpio_irq #(
    .N_BTN(4), .N_LED(16), .N_SW(16), .CNT_W(2), .DEB_CYCLES(4), .CNT_SATURATE(1'b1),
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)
  ) u_dut0 (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready0), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready0), .s_axi_bresp(bresp0), .s_axi_bvalid(bvalid0), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready0), .s_axi_rdata(rdata0), .s_axi_rresp(rresp0),
    .s_axi_rvalid(rvalid0), .s_axi_rready(rready),
    .sw(sw), .btn(btn), .led(led0), .irq(irq0)
  );

  axi_lite_gpio_irq #(
    .N_BTN(4), .N_LED(16), .N_SW(16), .CNT_W(2), .DEB_CYCLES(4), .CNT_SATURATE(1'b0),
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)
  ) u_dut1 (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready1), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready1), .s_axi_bresp(bresp1), .s_axi_bvalid(bvalid1), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready1), .s_axi_rdata(rdata1), .s_axi_rresp(rresp1),
    .s_axi_rvalid(rvalid1), .s_axi_rready(rready),
    .sw(sw), .btn(btn), .led(led1), .irq(irq1)
  );

  typedef struct {
    string       name;
    logic [1:0]  resp;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  exp_t we, re;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the oldest expectation on every B or R handshake.
  always @(negedge clk) begin
    if (bvalid0 && bready) begin
      if (wq.size() == 0) check("unexpected_bresp", 32'(bvalid0), 0);
      else begin
        we = wq.pop_front();
        check({we.name, "_bresp0"}, 32'(bresp0), 32'(we.resp));
        check({we.name, "_bresp1"}, 32'({bvalid1, bresp1}), 32'({1'b1, we.resp}));
      end
    end
    if (rvalid0 && rready) begin
      if (rq.size() == 0) check("unexpected_rresp", 32'(rvalid0), 0);
      else begin
        re = rq.pop_front();
        check({re.name, "_rresp0"}, 32'(rresp0), 32'(re.resp));
        check({re.name, "_rdata0"}, rdata0, re.d0);
        check({re.name, "_rresp1"}, 32'({rvalid1, rresp1}), 32'({1'b1, re.resp}));
        check({re.name, "_rdata1"}, rdata1, re.d1);
      end
    end
  end

  task automatic push_w(input string name, input logic [1:0] resp);
    exp_t e;
    e.name = name; e.resp = resp; e.d0 = '0; e.d1 = '0;
    wq.push_back(e);
  endtask

  task automatic push_r(input string name, input logic [1:0] resp, input logic [31:0] d0,
                        input logic [31:0] d1);
    exp_t e;
    e.name = name; e.resp = resp; e.d0 = d0; e.d1 = d1;
    rq.push_back(e);
  endtask

  // All bus tasks start and end just after a rising edge.
  task automatic axi_write(input string name, input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input int hold = 0,
                           input int irq_exp = -1);
    bit seen = 1'b0;
    push_w(name, resp);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    if (hold > 0) bready = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = awready0 && wready0;
    end
    if (!seen) check({name, "_aw_timeout"}, 0, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check({name, "_bvalid_latency"}, 32'(bvalid0), 1);
    if (irq_exp >= 0) check({name, "_irq_during_b"}, 32'(irq0), irq_exp);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); @(negedge clk);
        check({name, "_b_hold"}, 32'({bvalid0, bresp0}), 32'({1'b1, resp}));
      end
      @(posedge clk); #1;
      bready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input string name, input logic [5:0] addr, input logic [1:0] resp,
                          input logic [31:0] d0, input logic [31:0] d1);
    bit seen = 1'b0;
    push_r(name, resp, d0, d1);
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = arready0;
    end
    if (!seen) check({name, "_ar_timeout"}, 0, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check({name, "_rvalid_latency"}, 32'(rvalid0), 1);
    @(posedge clk); #1;
  endtask

  task automatic press(input int k, input int n);
    btn[k] = 1'b1;
    repeat (n) @(posedge clk);
    #1 btn[k] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    aresetn = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    sw = '0; btn = '0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    check("reset_handshakes0", 32'({awready0, wready0, bvalid0, arready0, rvalid0}), 0);
    check("reset_handshakes1", 32'({awready1, wready1, bvalid1, arready1, rvalid1}), 0);
    check("reset_resp_rdata", 32'({bresp0, rresp0}) | rdata0, 0);
    check("reset_led_irq", 32'({led0, led1, irq0, irq1}), 0);

    axi_read("rd_config_rst", 6'h00, 2'b00, 0, 0);
    axi_read("rd_led_rst",    6'h04, 2'b00, 0, 0);
    axi_read("rd_pend_rst",   6'h14, 2'b00, 0, 0);

    axi_write("wr_led_all", 6'h04, 32'h0000_FFFF, 4'hF, 2'b00);
    check("led_all", 32'({led0, led1}), 32'hFFFF_FFFF);
    axi_write("wr_led_byte0", 6'h04, 32'h0000_A5A5, 4'h1, 2'b00, 5);
    check("led_strobed", 32'({led0, led1}), 32'hFFA5_FFA5);
    axi_read("rd_led", 6'h07, 2'b00, 32'hFFA5, 32'hFFA5);

    sw = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    axi_read("rd_sw", 6'h08, 2'b00, 32'h1234, 32'h1234);

    axi_write("wr_sw_ro",    6'h08, 32'h0000_0000, 4'hF, 2'b10);
    axi_write("wr_count_ro", 6'h20, 32'h0000_0003, 4'hF, 2'b10);
    axi_write("wr_unmapped", 6'h18, 32'h0000_0000, 4'hF, 2'b10);
    check("led_after_slverr", 32'({led0, led1}), 32'hFFA5_FFA5);
    axi_read("rd_0x30",      6'h30, 2'b10, 0, 0);
    axi_read("rd_0x18",      6'h18, 2'b10, 0, 0);

    // Debounce: a 3-cycle glitch is rejected, a 10-cycle hold is accepted
    press(2, 3);
    axi_read("rd_level_glitch", 6'h0C, 2'b00, 0, 0);
    axi_read("rd_cnt2_glitch",  6'h28, 2'b00, 0, 0);
    btn[2] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    axi_read("rd_level_held", 6'h0C, 2'b00, 32'h4, 32'h4);
    axi_read("rd_cnt2_first", 6'h28, 2'b00, 1, 1);
    axi_read("rd_cnt2_clear", 6'h28, 2'b00, 0, 0);
    btn[2] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    axi_write("wr_keep", 6'h00, 32'h1, 4'hF, 2'b00);
    press(2, 10);
    axi_read("rd_cnt2_keep_a", 6'h28, 2'b00, 1, 1);
    axi_read("rd_cnt2_keep_b", 6'h28, 2'b00, 1, 1);

    // Five presses on a 2-bit counter: saturate at 3 vs wrap to 1
    for (int i = 0; i < 5; i++) press(1, 10);
    axi_read("rd_cnt1_five", 6'h24, 2'b00, 3, 1);

    // Press pulse lands on the clearing read's handshake edge
    axi_write("wr_nokeep", 6'h00, 32'h0, 4'hF, 2'b00);
    btn[3] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    axi_read("rd_cnt3_coincident", 6'h2C, 2'b00, 0, 0);
    repeat (3) @(posedge clk);
    #1 btn[3] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    axi_read("rd_cnt3_after", 6'h2C, 2'b00, 1, 1);

    // Interrupt path
    axi_write("wr_irq_en", 6'h10, 32'h1, 4'hF, 2'b00);
    axi_write("wr_gie",    6'h00, 32'h2, 4'hF, 2'b00);
    btn[0] = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("irq_before_rise", 32'({irq0, irq1}), 0);
    @(negedge clk);
    check("irq_rise", 32'({irq0, irq1}), 3);
    repeat (3) @(posedge clk);
    #1 btn[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    axi_read("rd_pend_set", 6'h14, 2'b00, 1, 1);

    btn[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    axi_write("wr_w1c_with_press", 6'h14, 32'h1, 4'hF, 2'b00);
    repeat (4) @(posedge clk);
    #1 btn[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    axi_read("rd_pend_set_wins", 6'h14, 2'b00, 1, 1);
    check("irq_after_set_wins", 32'({irq0, irq1}), 3);

    axi_write("wr_w1c_nostrb", 6'h14, 32'h1, 4'h0, 2'b00);
    axi_read("rd_pend_nostrb", 6'h14, 2'b00, 1, 1);
    axi_write("wr_irq_en_off", 6'h10, 32'h0, 4'hF, 2'b00);
    axi_read("rd_pend_en_off", 6'h14, 2'b00, 1, 1);
    check("irq_masked", 32'({irq0, irq1}), 0);
    axi_write("wr_irq_en_on", 6'h10, 32'h1, 4'hF, 2'b00);
    check("irq_unmasked", 32'({irq0, irq1}), 3);
    axi_write("wr_w1c_clear", 6'h14, 32'h1, 4'h1, 2'b00, 0, 1);
    check("irq_fall", 32'({irq0, irq1}), 0);
    axi_read("rd_pend_clear", 6'h14, 2'b00, 0, 0);

    // Same-cycle read and write of LED: read returns the pre-write value
    push_w("rw_wr", 2'b00);
    push_r("rw_rd", 2'b00, 32'hFFA5, 32'hFFA5);
    awaddr = 6'h04; wdata = 32'h12; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h04; arvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = awready0 && arready0;
    end
    check("rw_same_cycle_ready", 32'(seen), 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("rw_both_valid", 32'({bvalid0, rvalid0}), 3);
    @(posedge clk); #1;
    axi_read("rd_led_after_rw", 6'h04, 2'b00, 32'hFF12, 32'hFF12);

    // Reset while a read response is waiting on rready
    rready = 1'b0;
    araddr = 6'h04; arvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = arready0;
    end
    check("rst_mid_ar_ready", 32'(seen), 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("rst_mid_rvalid_before", 32'({rvalid0, rvalid1}), 3);
    @(posedge clk); #1;
    aresetn = 1'b0;
    @(negedge clk);
    check("rst_mid_rvalid_held", 32'({rvalid0, rvalid1}), 3);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_rvalid_dropped", 32'({rvalid0, rvalid1}), 0);
    @(posedge clk); #1;
    aresetn = 1'b1; rready = 1'b1;
    check("rst_mid_led", 32'({led0, led1}), 0);
    axi_read("rd_led_post_rst", 6'h04, 2'b00, 0, 0);

    repeat (3) @(posedge clk);
    check("queues_drained", 32'(wq.size() + rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
